// File: rtl/spi_wb_cmd_master_if.sv
// Byte-level SPI slave handshake plus Wishbone master signals for spi_wb_cmd_master.
`default_nettype none

interface spi_wb_cmd_master_if;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_wdat;
  logic [3:0]  wb_sel;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_err;
  logic        busy;

  modport master (
    input  cs_n, rx_valid, rx_byte, tx_load, wb_rdat, wb_ack, wb_err,
    output tx_byte, wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat, wb_sel, busy
  );

  modport slave (
    output cs_n, rx_valid, rx_byte, tx_load, wb_rdat, wb_ack, wb_err,
    input  tx_byte, wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat, wb_sel, busy
  );
endinterface

`default_nettype wire

// File: rtl/spi_wb_cmd_master.sv
// spi_wb_cmd_master: decodes SPI command frames (A1 read / A2 write) into single Wishbone cycles.
// Optional macro SPIWB_TIMEOUT_EN adds a Wishbone watchdog (response header A4, data DEADBEEF).
`default_nettype none

module spi_wb_cmd_master #(
  parameter logic [7:0] PAD_BYTE       = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_wb_cmd_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WDATA   = 3'd2,
    WB_REQ  = 3'd3,
    WB_WAIT = 3'd4,
    RESP    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_RD   = 8'hA1;
  localparam logic [7:0] CMD_WR   = 8'hA2;
  localparam logic [7:0] HDR_OK   = 8'hA3;

`ifdef SPIWB_TIMEOUT_EN
  localparam logic [7:0]  HDR_TMO  = 8'hA4;
  localparam logic [31:0] DAT_TMO  = 32'hDEADBEEF;
  localparam int          TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  state_t      state;
  logic        is_write;
  logic        abort;
  logic [1:0]  byte_cnt;
  logic [2:0]  resp_idx;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  rd_byte;

  // Byte that follows the one currently on tx_byte once the slave loads it.
  always_comb begin
    rd_byte = rdata[7:0];
    case (resp_idx[1:0])
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      2'd3:    rd_byte = rdata[31:24];
      default: rd_byte = rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      abort       <= 1'b0;
      byte_cnt    <= 2'd0;
      resp_idx    <= 3'd0;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      rdata       <= 32'h0;
      bus.tx_byte <= PAD_BYTE;
      bus.wb_cyc  <= 1'b0;
      bus.wb_stb  <= 1'b0;
      bus.wb_we   <= 1'b0;
      bus.wb_adr  <= 32'h0;
      bus.wb_wdat <= 32'h0;
      bus.wb_sel  <= 4'h0;
      bus.busy    <= 1'b0;
`ifdef SPIWB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!bus.cs_n && bus.rx_valid) begin
            bus.busy <= 1'b1;
            byte_cnt <= 2'd0;
            addr     <= 32'h0;
            wdata    <= 32'h0;
            abort    <= 1'b0;
            if (bus.rx_byte == CMD_RD) begin
              is_write <= 1'b0;
              state    <= ADDR;
            end else if (bus.rx_byte == CMD_WR) begin
              is_write <= 1'b1;
              state    <= ADDR;
            end else begin
              state    <= DRAIN;
            end
          end
        end

        ADDR: begin
          if (bus.cs_n) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.tx_byte <= PAD_BYTE;
          end else if (bus.rx_valid) begin
            addr     <= {addr[23:0], bus.rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= is_write ? WDATA : WB_REQ;
          end
        end

        WDATA: begin
          if (bus.cs_n) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.tx_byte <= PAD_BYTE;
          end else if (bus.rx_valid) begin
            wdata    <= {bus.rx_byte, wdata[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= WB_REQ;
          end
        end

        WB_REQ: begin
          bus.wb_cyc  <= 1'b1;
          bus.wb_stb  <= 1'b1;
          bus.wb_we   <= is_write;
          bus.wb_sel  <= 4'hF;
          bus.wb_adr  <= addr;
          bus.wb_wdat <= wdata;
          if (bus.cs_n)
            abort <= 1'b1;
`ifdef SPIWB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WB_WAIT;
        end

        WB_WAIT: begin
          if (bus.cs_n)
            abort <= 1'b1;
          if (bus.wb_ack || bus.wb_err) begin
            bus.wb_cyc <= 1'b0;
            bus.wb_stb <= 1'b0;
            bus.wb_we  <= 1'b0;
            bus.wb_sel <= 4'h0;
            // A frame that ended mid-cycle still completes the bus cycle, then drops the result.
            if (abort || bus.cs_n) begin
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.tx_byte <= PAD_BYTE;
            end else if (is_write) begin
              state <= DRAIN;
            end else begin
              rdata       <= (bus.wb_ack && !bus.wb_err) ? bus.wb_rdat : 32'h0;
              resp_idx    <= 3'd0;
              bus.tx_byte <= HDR_OK;
              state       <= RESP;
            end
          end
`ifdef SPIWB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            bus.wb_cyc <= 1'b0;
            bus.wb_stb <= 1'b0;
            bus.wb_we  <= 1'b0;
            bus.wb_sel <= 4'h0;
            if (abort || bus.cs_n) begin
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.tx_byte <= PAD_BYTE;
            end else if (is_write) begin
              state <= DRAIN;
            end else begin
              rdata       <= DAT_TMO;
              resp_idx    <= 3'd0;
              bus.tx_byte <= HDR_TMO;
              state       <= RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        RESP: begin
          if (bus.cs_n) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.tx_byte <= PAD_BYTE;
          end else if (bus.tx_load) begin
            if (resp_idx == 3'd4) begin
              bus.tx_byte <= PAD_BYTE;
              state       <= DRAIN;
            end else begin
              bus.tx_byte <= rd_byte;
              resp_idx    <= resp_idx + 3'd1;
            end
          end
        end

        DRAIN: begin
          if (bus.cs_n) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.tx_byte <= PAD_BYTE;
          end
        end

        default: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.tx_byte <= PAD_BYTE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
